// File: rtl/dep_rule_conf_shadow.sv
// Double-buffered deparser rule configuration: config-bus writes build a shadow
// rule set that is copied atomically to the active outputs once the pipeline idles.
module dep_rule_conf_shadow #(
  parameter int RULE_NUM          = 16,
  parameter int TYPE_NUM          = 4,
  parameter int TYPE_WIDTH        = 16,
  parameter int TYPE_OFFSET_WIDTH = 6,
  parameter int KEY_NUM           = 8,
  parameter int KEY_OFFSET_WIDTH  = 5,
  parameter int HEAD_SHIFT_WIDTH  = 6,
  parameter int META_SHIFT_WIDTH  = 6,
  parameter int TIMEOUT           = 1024
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst_n,
  input  logic                                      i_rule_wren,
  input  logic                                      i_rule_rden,
  input  logic [31:0]                               i_rule_addr,
  input  logic [31:0]                               i_rule_wdata,
  output logic [31:0]                               o_rule_rdata,
  output logic                                      o_rule_rvalid,
  input  logic                                      i_pipe_idle,
  output logic                                      o_busy,
  output logic [RULE_NUM-1:0]                       o_rule_wren,
  output logic                                      o_rule_valid,
  output logic [TYPE_NUM*TYPE_WIDTH-1:0]            o_type_data,
  output logic [TYPE_NUM*TYPE_WIDTH-1:0]            o_type_mask,
  output logic [TYPE_NUM*TYPE_OFFSET_WIDTH-1:0]     o_type_offset,
  output logic [KEY_NUM*(KEY_OFFSET_WIDTH+1)-1:0]   o_key_offset,
  output logic [KEY_NUM*KEY_OFFSET_WIDTH-1:0]       o_key_merge,
  output logic [HEAD_SHIFT_WIDTH-1:0]               o_head_shift,
  output logic [META_SHIFT_WIDTH-1:0]               o_meta_shift
);

  localparam int TW    = TYPE_WIDTH;
  localparam int TOW   = TYPE_OFFSET_WIDTH;
  localparam int KOW   = KEY_OFFSET_WIDTH;
  localparam int KW    = KEY_OFFSET_WIDTH + 1;
  localparam int HSW   = HEAD_SHIFT_WIDTH;
  localparam int MSW   = META_SHIFT_WIDTH;
  localparam int TI_W  = (TYPE_NUM > 1) ? $clog2(TYPE_NUM) : 1;
  localparam int KI_W  = (KEY_NUM > 1) ? $clog2(KEY_NUM) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_APPLY} state_t;

  state_t              state;
  logic [CNT_W-1:0]    wait_cnt;
  logic                rule_pend;
  logic                to_flag;
  logic                drop_flag;

  logic [5:0]          sh_rule_id;
  logic                sh_rule_vld;
  logic [TW-1:0]       sh_tdata [TYPE_NUM];
  logic [TW-1:0]       sh_tmask [TYPE_NUM];
  logic [TOW-1:0]      sh_toff  [TYPE_NUM];
  logic [KW-1:0]       sh_koff  [KEY_NUM];
  logic [KOW-1:0]      sh_kmrg  [KEY_NUM];
  logic [HSW-1:0]      sh_head;
  logic [MSW-1:0]      sh_meta;

  logic [TW-1:0]       act_tdata [TYPE_NUM];
  logic [TW-1:0]       act_tmask [TYPE_NUM];
  logic [TOW-1:0]      act_toff  [TYPE_NUM];
  logic [KW-1:0]       act_koff  [KEY_NUM];
  logic [KOW-1:0]      act_kmrg  [KEY_NUM];
  logic [HSW-1:0]      act_head;
  logic [MSW-1:0]      act_meta;

  logic [31:0]         rd_data_p1;
  logic                rd_vld_p1;
  logic [31:0]         rd_mux;

  logic [2:0]          region;
  logic [5:0]          idx;
  logic [TI_W-1:0]     t_sel;
  logic [KI_W-1:0]     k_sel;
  logic                t_idx_ok;
  logic                k_idx_ok;
  logic                r_idx_ok;
  logic                wr_ok;
  logic                drop_set;
  logic                unused_bits;

  assign region   = i_rule_addr[10:8];
  assign idx      = i_rule_addr[5:0];
  assign t_sel    = i_rule_addr[TI_W-1:0];
  assign k_sel    = idx[KI_W-1:0];
  assign t_idx_ok = int'(i_rule_addr[3:0]) < TYPE_NUM;
  assign k_idx_ok = int'(idx) < KEY_NUM;
  assign r_idx_ok = int'(idx) < RULE_NUM;
  assign o_busy   = (state != S_IDLE);
  // Writes are only accepted while idle so the shadow is frozen during a commit.
  assign wr_ok    = i_rule_wren && !o_busy;
  assign drop_set = i_rule_wren && o_busy && (region != 3'd7);
  assign unused_bits = ^{i_rule_addr[31:11], i_rule_addr[7:6], i_rule_wdata};

  // Shadow rule set: written by the config bus, restored from active on discard.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sh_rule_id  <= '0;
      sh_rule_vld <= 1'b0;
      sh_head     <= '0;
      sh_meta     <= '0;
      for (int i = 0; i < TYPE_NUM; i++) begin
        sh_tdata[i] <= '0;
        sh_tmask[i] <= '0;
        sh_toff[i]  <= '0;
      end
      for (int i = 0; i < KEY_NUM; i++) begin
        sh_koff[i] <= '0;
        sh_kmrg[i] <= '0;
      end
    end else if (wr_ok) begin
      case (region)
        3'd0: if (r_idx_ok) begin
          sh_rule_id  <= idx;
          sh_rule_vld <= i_rule_wdata[0];
        end
        3'd1: if (t_idx_ok) begin
          sh_tdata[t_sel] <= i_rule_wdata[16 +: TW];
          sh_tmask[t_sel] <= i_rule_wdata[0 +: TW];
        end
        3'd2: if (t_idx_ok) sh_toff[t_sel] <= i_rule_wdata[0 +: TOW];
        3'd3: if (k_idx_ok) begin
          sh_koff[k_sel] <= {i_rule_wdata[16], i_rule_wdata[0 +: KOW]};
          sh_kmrg[k_sel] <= i_rule_wdata[8 +: KOW];
        end
        3'd4: sh_head <= i_rule_wdata[0 +: HSW];
        3'd5: sh_meta <= i_rule_wdata[0 +: MSW];
        3'd6: if (i_rule_wdata[1]) begin
          sh_head <= act_head;
          sh_meta <= act_meta;
          for (int i = 0; i < TYPE_NUM; i++) begin
            sh_tdata[i] <= act_tdata[i];
            sh_tmask[i] <= act_tmask[i];
            sh_toff[i]  <= act_toff[i];
          end
          for (int i = 0; i < KEY_NUM; i++) begin
            sh_koff[i] <= act_koff[i];
            sh_kmrg[i] <= act_kmrg[i];
          end
        end
        default: ;
      endcase
    end
  end

  // Active rule set: loaded from shadow in the single APPLY cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      act_head <= '0;
      act_meta <= '0;
      for (int i = 0; i < TYPE_NUM; i++) begin
        act_tdata[i] <= '0;
        act_tmask[i] <= '0;
        act_toff[i]  <= '0;
      end
      for (int i = 0; i < KEY_NUM; i++) begin
        act_koff[i] <= '0;
        act_kmrg[i] <= '0;
      end
    end else if (state == S_APPLY) begin
      act_head <= sh_head;
      act_meta <= sh_meta;
      for (int i = 0; i < TYPE_NUM; i++) begin
        act_tdata[i] <= sh_tdata[i];
        act_tmask[i] <= sh_tmask[i];
        act_toff[i]  <= sh_toff[i];
      end
      for (int i = 0; i < KEY_NUM; i++) begin
        act_koff[i] <= sh_koff[i];
        act_kmrg[i] <= sh_kmrg[i];
      end
    end
  end

  // Commit FSM, staging flag, sticky flags and the rule write pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      wait_cnt     <= '0;
      rule_pend    <= 1'b0;
      to_flag      <= 1'b0;
      drop_flag    <= 1'b0;
      o_rule_wren  <= '0;
      o_rule_valid <= 1'b0;
    end else begin
      o_rule_wren  <= '0;
      o_rule_valid <= 1'b0;
      if (drop_set) drop_flag <= 1'b1;
      if (wr_ok && region == 3'd0 && r_idx_ok) rule_pend <= 1'b1;
      case (state)
        S_IDLE: begin
          if (wr_ok && region == 3'd6) begin
            if (i_rule_wdata[2]) begin
              to_flag   <= 1'b0;
              drop_flag <= 1'b0;
            end
            if (i_rule_wdata[1]) begin
              rule_pend <= 1'b0;
            end else if (i_rule_wdata[0]) begin
              state    <= S_WAIT;
              wait_cnt <= '0;
            end
          end
        end
        S_WAIT: begin
          if (i_pipe_idle) begin
            state <= S_APPLY;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            state   <= S_IDLE;
            to_flag <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_APPLY: begin
          state <= S_IDLE;
          if (rule_pend) begin
            o_rule_wren  <= RULE_NUM'(1) << sh_rule_id;
            o_rule_valid <= sh_rule_vld;
            rule_pend    <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (region)
      3'd1: if (t_idx_ok) begin
        rd_mux[16 +: TW] = sh_tdata[t_sel];
        rd_mux[0 +: TW]  = sh_tmask[t_sel];
      end
      3'd2: if (t_idx_ok) rd_mux[0 +: TOW] = sh_toff[t_sel];
      3'd3: if (k_idx_ok) begin
        rd_mux[16]        = sh_koff[k_sel][KOW];
        rd_mux[8 +: KOW]  = sh_kmrg[k_sel];
        rd_mux[0 +: KOW]  = sh_koff[k_sel][KOW-1:0];
      end
      3'd4: rd_mux[0 +: HSW] = sh_head;
      3'd5: rd_mux[0 +: MSW] = sh_meta;
      3'd7: rd_mux[3:0] = {drop_flag, to_flag, o_busy, rule_pend};
      default: ;
    endcase
  end

  // Read stage p1: one-cycle registered readback of pre-write state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_data_p1 <= '0;
      rd_vld_p1  <= 1'b0;
    end else begin
      rd_vld_p1 <= i_rule_rden;
      if (i_rule_rden) rd_data_p1 <= rd_mux;
    end
  end

  assign o_rule_rdata  = rd_data_p1;
  assign o_rule_rvalid = rd_vld_p1;
  assign o_head_shift  = act_head;
  assign o_meta_shift  = act_meta;

  for (genvar g = 0; g < TYPE_NUM; g++) begin : g_type
    assign o_type_data[g*TW +: TW]     = act_tdata[g];
    assign o_type_mask[g*TW +: TW]     = act_tmask[g];
    assign o_type_offset[g*TOW +: TOW] = act_toff[g];
  end

  for (genvar g = 0; g < KEY_NUM; g++) begin : g_key
    assign o_key_offset[g*KW +: KW]   = act_koff[g];
    assign o_key_merge[g*KOW +: KOW]  = act_kmrg[g];
  end

endmodule
